// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, write, reserve and control signals of the decode-stage register file.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  init_req;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] rs_1;
    logic [ADDR_WIDTH-1:0] rs_2;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  rs_1_busy;
    logic                  rs_2_busy;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  reserve_enable;
    logic [ADDR_WIDTH-1:0] reserve_addr;

    modport master (
        output init_req, rs_1, rs_2, write_enable, write_addr, write_data, reserve_enable, reserve_addr,
        input  ready, read_data_1, read_data_2, rs_1_busy, rs_2_busy
    );

    modport slave (
        input  init_req, rs_1, rs_2, write_enable, write_addr, write_data, reserve_enable, reserve_addr,
        output ready, read_data_1, read_data_2, rs_1_busy, rs_2_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with two combinational read ports, write bypass,
// hardwired zero register, busy scoreboard and a sequential clear after reset/init_req.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input logic                clk,
    input logic                reset,
    regfile_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [NUM_REGS-1:0]   busy;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  run, wr_ok, rsv_ok;
    logic                  zero_1, zero_2, byp_1, byp_2, hold_1, hold_2;

    assign run    = state == RUN;
    // init_req discards any write or reserve landing on the same edge
    assign wr_ok  = run && !bus.init_req && bus.write_enable &&
                    !(ZERO_REG != 0 && bus.write_addr == '0);
    assign rsv_ok = run && !bus.init_req && bus.reserve_enable &&
                    !(ZERO_REG != 0 && bus.reserve_addr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_ptr == ADDR_WIDTH'(NUM_REGS - 1)) state_next = RUN;
        else if (run && bus.init_req)                              state_next = CLEAR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_ptr <= '0;
            busy    <= '0;
        end else begin
            clr_ptr <= run ? '0 : clr_ptr + 1'b1;
            if (!run || bus.init_req) begin
                busy <= '0;
            end else begin
                if (wr_ok)  busy[bus.write_addr]   <= 1'b0;
                if (rsv_ok) busy[bus.reserve_addr] <= 1'b1;
            end
        end
    end

    // Contents are never reset; the clear walk zeroes them one per edge instead
    always_ff @(posedge clk) begin
        if (!run)       regs[clr_ptr]        <= '0;
        else if (wr_ok) regs[bus.write_addr] <= bus.write_data;
    end

    always_comb begin
        zero_1          = !run || (ZERO_REG != 0 && bus.rs_1 == '0);
        zero_2          = !run || (ZERO_REG != 0 && bus.rs_2 == '0);
        byp_1           = BYPASS != 0 && bus.write_enable && bus.write_addr == bus.rs_1;
        byp_2           = BYPASS != 0 && bus.write_enable && bus.write_addr == bus.rs_2;
        hold_1          = bus.reserve_enable && bus.reserve_addr == bus.rs_1;
        hold_2          = bus.reserve_enable && bus.reserve_addr == bus.rs_2;
        bus.ready       = run;
        bus.read_data_1 = zero_1 ? '0 : byp_1 ? bus.write_data : regs[bus.rs_1];
        bus.read_data_2 = zero_2 ? '0 : byp_2 ? bus.write_data : regs[bus.rs_2];
        // A forwarded write retires the producer unless a new one is issued alongside it
        bus.rs_1_busy   = !zero_1 && busy[bus.rs_1] && !(byp_1 && !hold_1);
        bus.rs_2_busy   = !zero_2 && busy[bus.rs_2] && !(byp_2 && !hold_2);
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: vector table, hand-written corner sequences and random traffic
// against an array-based model, on a default instance and a BYPASS=0/ZERO_REG=0 instance.
module tb_regfile_scoreboard;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nb ();

    regfile_scoreboard u_dut (.clk(clk), .reset(reset), .bus(bus));
    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) u_nb (.clk(clk), .reset(reset), .bus(bus_nb));

    assign bus_nb.init_req       = bus.init_req;
    assign bus_nb.rs_1           = bus.rs_1;
    assign bus_nb.rs_2           = bus.rs_2;
    assign bus_nb.write_enable   = bus.write_enable;
    assign bus_nb.write_addr     = bus.write_addr;
    assign bus_nb.write_data     = bus.write_data;
    assign bus_nb.reserve_enable = bus.reserve_enable;
    assign bus_nb.reserve_addr   = bus.reserve_addr;

    always #5 clk = ~clk;

    // Model: index 0 = default instance, 1 = no bypass / no zero register
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    bit          m_ready;
    int          m_cnt;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rd1;
        logic        b1;
        logic [31:0] rd2;
        logic        b2;
        logic [31:0] nrd1;
        logic        nb1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input int p, input logic [4:0] a);
        if (!m_ready || (p == 0 && a == 0)) return 32'd0;
        if (p == 0 && bus.write_enable && bus.write_addr == a) return bus.write_data;
        return m_mem[p][a];
    endfunction

    function automatic logic exp_busy(input int p, input logic [4:0] a);
        if (!m_ready || (p == 0 && a == 0)) return 1'b0;
        if (p == 0 && bus.write_enable && bus.write_addr == a &&
            !(bus.reserve_enable && bus.reserve_addr == a)) return 1'b0;
        return m_busy[p][a];
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 32; i++) begin
                m_mem[p][i]  = '0;
                m_busy[p][i] = 1'b0;
            end
    endtask

    task automatic model_reset();
        m_ready = 0;
        m_cnt   = 0;
        model_clear();
    endtask

    task automatic model_edge();
        if (!m_ready) begin
            m_cnt++;
            if (m_cnt == 32) m_ready = 1;
        end else if (bus.init_req) begin
            m_ready = 0;
            m_cnt   = 0;
            model_clear();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (bus.write_enable && !(p == 0 && bus.write_addr == 0)) begin
                    m_mem[p][bus.write_addr]  = bus.write_data;
                    m_busy[p][bus.write_addr] = 1'b0;
                end
                if (bus.reserve_enable && !(p == 0 && bus.reserve_addr == 0))
                    m_busy[p][bus.reserve_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("m_ready",     bus.ready,            m_ready);
        chk("m_ready_nb",  bus_nb.ready,         m_ready);
        chk("m_rd1",       bus.read_data_1,      exp_rd(0, bus.rs_1));
        chk("m_rd2",       bus.read_data_2,      exp_rd(0, bus.rs_2));
        chk("m_b1",        bus.rs_1_busy,        exp_busy(0, bus.rs_1));
        chk("m_b2",        bus.rs_2_busy,        exp_busy(0, bus.rs_2));
        chk("m_rd1_nb",    bus_nb.read_data_1,   exp_rd(1, bus.rs_1));
        chk("m_rd2_nb",    bus_nb.read_data_2,   exp_rd(1, bus.rs_2));
        chk("m_b1_nb",     bus_nb.rs_1_busy,     exp_busy(1, bus.rs_1));
        chk("m_b2_nb",     bus_nb.rs_2_busy,     exp_busy(1, bus.rs_2));
    endtask

    // Entered at posedge+1 with inputs set; leaves at the next posedge+1
    task automatic cycle();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        bus.init_req       = 1'b0;
        bus.write_enable   = 1'b0;
        bus.write_addr     = '0;
        bus.write_data     = '0;
        bus.reserve_enable = 1'b0;
        bus.reserve_addr   = '0;
    endtask

    task automatic set_ops(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic re, input logic [4:0] ra);
        idle();
        bus.write_enable   = we;
        bus.write_addr     = wa;
        bus.write_data     = wd;
        bus.reserve_enable = re;
        bus.reserve_addr   = ra;
    endtask

    initial begin
        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 32'h12345678, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 0};
        tbl[2]  = '{0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 7, 5, 0, 1, 32'hDEADBEEF, 0, 0, 1};
        tbl[4]  = '{1, 7, 32'hA5A5A5A5, 0, 0, 7, 5, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 7, 5, 32'hA5A5A5A5, 0, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 0};
        tbl[6]  = '{0, 0, 0, 1, 3, 0, 3, 0, 0, 0, 0, 32'h12345678, 0};
        tbl[7]  = '{1, 3, 32'h11112222, 1, 3, 0, 3, 0, 0, 32'h11112222, 1, 32'h12345678, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 3, 3, 32'h11112222, 1, 32'h11112222, 1, 32'h11112222, 1};
        tbl[9]  = '{1, 3, 32'h33334444, 0, 0, 3, 3, 32'h33334444, 0, 32'h33334444, 0, 32'h11112222, 1};
        tbl[10] = '{0, 0, 0, 1, 0, 0, 3, 0, 0, 32'h33334444, 0, 32'h12345678, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 1};

        idle();
        bus.rs_1 = 5'd1;
        bus.rs_2 = 5'd2;
        reset    = 1'b1;
        model_reset();
        #1;
        chk("reset_ready", bus.ready,       0);
        chk("reset_rd1",   bus.read_data_1, 0);
        chk("reset_rd2",   bus.read_data_2, 0);
        chk("reset_b1",    bus.rs_1_busy,   0);
        chk("reset_b2",    bus.rs_2_busy,   0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Clear with every strobe held high: all of it must be ignored
        for (int e = 1; e <= 32; e++) begin
            set_ops(1, 5'($urandom_range(0, 31)), 32'hFFFFFFFF, 1, 5'($urandom_range(0, 31)));
            bus.init_req = 1'b1;
            bus.rs_1     = 5'($urandom_range(0, 31));
            cycle();
            chk("clear_ready", bus.ready, (e == 32) ? 1 : 0);
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            bus.rs_1 = 5'(i);
            bus.rs_2 = 5'(31 - i);
            #1;
            chk("clear_rd1",    bus.read_data_1,    0);
            chk("clear_b1",     bus.rs_1_busy,      0);
            chk("clear_rd1_nb", bus_nb.read_data_1, 0);
            chk("clear_b1_nb",  bus_nb.rs_1_busy,   0);
            cycle();
        end

        for (int i = 0; i < 12; i++) begin
            set_ops(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra);
            bus.rs_1 = tbl[i].rs1;
            bus.rs_2 = tbl[i].rs2;
            #1;
            chk($sformatf("tbl%0d_rd1", i),    bus.read_data_1,    tbl[i].rd1);
            chk($sformatf("tbl%0d_b1", i),     bus.rs_1_busy,      tbl[i].b1);
            chk($sformatf("tbl%0d_rd2", i),    bus.read_data_2,    tbl[i].rd2);
            chk($sformatf("tbl%0d_b2", i),     bus.rs_2_busy,      tbl[i].b2);
            chk($sformatf("tbl%0d_nb_rd1", i), bus_nb.read_data_1, tbl[i].nrd1);
            chk($sformatf("tbl%0d_nb_b1", i),  bus_nb.rs_1_busy,   tbl[i].nb1);
            cycle();
        end

        // Asynchronous reset between edges, after x9 was written then reserved
        set_ops(1, 9, 32'h99999999, 0, 0);
        cycle();
        set_ops(0, 0, 0, 1, 9);
        bus.rs_1 = 5'd9;
        cycle();
        idle();
        #1;
        chk("pre_reset_b1", bus.rs_1_busy, 1);
        reset = 1'b1;
        #1;
        chk("async_reset_ready",    bus.ready,    0);
        chk("async_reset_ready_nb", bus_nb.ready, 0);
        chk("async_reset_b1",       bus.rs_1_busy, 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) cycle();
        bus.rs_1 = 5'd9;
        bus.rs_2 = 5'd9;
        #1;
        chk("reset_clear_ready", bus.ready,          1);
        chk("reset_clear_rd1",   bus.read_data_1,    0);
        chk("reset_clear_b1",    bus.rs_1_busy,      0);
        chk("reset_clear_nb_rd", bus_nb.read_data_2, 0);
        cycle();

        // init_req with a write and reserve on the same edge
        set_ops(1, 9, 32'h09090909, 1, 9);
        cycle();
        set_ops(1, 10, 32'h0A0A0A0A, 1, 11);
        bus.init_req = 1'b1;
        cycle();
        idle();
        chk("init_ready_drop", bus.ready, 0);
        for (int e = 1; e <= 31; e++) cycle();
        chk("init_ready_still_low", bus.ready, 0);
        cycle();
        bus.rs_1 = 5'd9;
        bus.rs_2 = 5'd10;
        #1;
        chk("init_ready_back", bus.ready,       1);
        chk("init_rd9",        bus.read_data_1, 0);
        chk("init_b9",         bus.rs_1_busy,   0);
        chk("init_rd10",       bus.read_data_2, 0);
        bus.rs_2 = 5'd11;
        #1;
        chk("init_b11",        bus.rs_2_busy,   0);
        cycle();

        for (int n = 0; n < 600; n++) begin
            set_ops($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
            bus.init_req = $urandom_range(0, 79) == 0;
            bus.rs_1     = 5'($urandom_range(0, 7));
            bus.rs_2     = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with clocked writes, two combinational read ports, optional write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for hazard detection. After reset it runs a sequential clear state machine that zeroes every register, then raises `ready`. It sits in the decode stage of the RV32I core. Operands are read here. The scoreboard tells the hazard unit whether a source register is still waiting on an in-flight producer, such as a load or a multi-cycle op.

## Interface
- `DATA_WIDTH`, 32, register width in bits
- `ADDR_WIDTH`, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- `ZERO_REG`, 1, 1 = register 0 reads 0, ignores writes and reserves, and is never busy
- `BYPASS`, 1, 1 = same-cycle write data is forwarded to the read ports
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `init_req`  in  1  one-cycle pulse in RUN that restarts the clear sequence
- `ready`  out  1  high when in RUN state
- `rs_1`, `rs_2`  in  ADDR_WIDTH  read addresses
- `read_data_1`, `read_data_2`  out  DATA_WIDTH  read data (combinational)
- `rs_1_busy`, `rs_2_busy`  out  1  source register has a pending producer
- `write_enable`  in  1  write strobe; also releases the busy bit of `write_addr`
- `write_addr`  in  ADDR_WIDTH  write address
- `write_data`  in  DATA_WIDTH  write data
- `reserve_enable`  in  1  marks `reserve_addr` busy
- `reserve_addr`  in  ADDR_WIDTH  register to reserve

## Operation
- There are two states, CLEAR and RUN, plus a clear pointer `clr_ptr` of ADDR_WIDTH bits.
- **Reset:** `reset` high forces, asynchronously:
  - state = CLEAR, `clr_ptr` = 0, all busy bits = 0, `ready` = 0.
  - Register contents are not reset directly.
- **CLEAR state:** each rising edge writes 0 to `registers[clr_ptr]` and increments `clr_ptr`.
  - When `clr_ptr` = NUM_REGS-1, that edge writes the last register and moves to RUN; the pointer wraps to 0.
  - `write_enable`, `reserve_enable` and `init_req` are ignored.
  - `read_data_*` = 0 and `rs_*_busy` = 0.
- **RUN state, write:** if `write_enable` is high and the address is not zero-protected, `registers[write_addr]` <= `write_data` and `busy[write_addr]` <= 0.
- **RUN state, reserve:** if `reserve_enable` is high and the address is not zero-protected, `busy[reserve_addr]` <= 1.
  - Reserving an already-busy register leaves it busy. There is no error.
- **Simultaneous write and reserve to the same address:** the data is written and busy ends at 1. Reserve wins, because a new producer has been issued.
- **`init_req` in RUN:** next edge goes to CLEAR with `clr_ptr` = 0 and all busy bits = 0. A write or reserve on that same edge is discarded.
- **Reads in RUN:**
  - `read_data_n` = 0 if ZERO_REG and `rs_n` = 0.
  - Otherwise, with BYPASS=1, it equals `write_data` when `write_enable` is high and `write_addr` = `rs_n`.
  - Otherwise it equals `registers[rs_n]`.
- **Busy in RUN:** `rs_n_busy` = `busy[rs_n]`, masked to 0 when any of these holds:
  - ZERO_REG and `rs_n` = 0;
  - BYPASS=1, `write_enable` is high and `write_addr` = `rs_n`, unless a same-address reserve is also active.
- **ZERO_REG = 0:** register 0 behaves like any other register.

## Timing
- Reset values: `ready` = 0, `read_data_1`/`read_data_2` = 0, `rs_1_busy`/`rs_2_busy` = 0.
- `ready` rises after the NUM_REGS-th rising edge following `reset` deassertion. With the defaults that is edge 32.
- Reset asserted mid-sequence, in either state, drops `ready` immediately without waiting for a clock and restarts the full clear.
- Write latency is one edge. With BYPASS=0, read-after-write data is visible the cycle after the write edge.
- With BYPASS=1, the read is visible in the same cycle, combinationally.
- Reserve: busy is visible on `rs_n_busy` the cycle after the reserve edge.
- Reads are purely combinational from `rs_n`, state and the write port. There are no read enables.

## Test plan
- **Reset and clear:**
  - Stimulus: assert `reset`, release it, hold all strobes high with `write_data` = 0xFFFFFFFF.
  - Response: `ready` = 0 for 31 edges and rises after edge 32. Every register then reads 0x00000000 and every busy bit reads 0.
- **Write/read and zero register:**
  - Stimulus: write 0xDEADBEEF to x5 and 0x12345678 to x0.
  - Response: `rs_1` = 5 reads 0xDEADBEEF the next cycle; `rs_2` = 0 reads 0 with busy 0.
- **Bypass:**
  - Stimulus: in the same cycle, `write_enable` with x7 = 0xA5A5A5A5 and `rs_1` = 7, with x7 previously reserved.
  - Response: `read_data_1` = 0xA5A5A5A5 and `rs_1_busy` = 0 in that cycle. With BYPASS=0, the old value and `rs_1_busy` = 1 in that cycle.
- **Scoreboard:**
  - Stimulus: reserve x3; next cycle, write x3 and reserve x3 together.
  - Response: `rs_2_busy` = 1 for x3 before and after the combined edge, and x3 holds the new data. A later write alone clears busy.
- **Mid-operation reset and init_req:**
  - Stimulus: reserve x9 and write x9; then assert `reset` mid-cycle, or pulse `init_req`.
  - Response: `ready` drops. For `init_req` this happens on the next edge. x9 reads 0 and is not busy after the new clear completes in 32 edges.
